pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
Consumer end of the PLL `locked` interface.
- Takes the asynchronous `locked` flag from the ECP5 PLL clock generator.
- Synchronises and filters it into the local clock domain.
- Produces a clean, stretched, active-high reset and a ready flag for the logic in that domain, for example the 48 MHz or 6 MHz USB host core.
- Counts lock-loss events for debug LEDs and the status register.

Parameters:
LOCK_FILTER, 16, cycles the synchronised lock must stay continuously high before the hold phase starts (>=1)
HOLD_CYCLES, 1024, cycles reset is held after the filter passes (>=1)
LOSS_CNT_W, 8, width of the saturating lock-loss counter (>=1)

Ports:
clk  input  1  domain clock (a PLL output)
reset  input  1  synchronous, active-high reset
locked_i  input  1  PLL lock flag, asynchronous to clk
clear_i  input  1  synchronous pulse; clears loss_count_o and loss_sticky_o
rst_o  output  1  registered active-high reset to downstream logic
ready_o  output  1  registered; high only in RUN; always equals ~rst_o
loss_count_o  output  LOSS_CNT_W  saturating count of RUN->lock-loss events
loss_sticky_o  output  1  set on any lock loss from RUN

Behaviour:
- One clock (clk). Reset is synchronous and active-high, named `reset`.
- Synchroniser: 2-FF chain on locked_i, producing lock_s. Both flops reset to 0.
- While reset is high:
  - state=WAIT_LOCK, counter=0, sync flops=0
  - rst_o=1, ready_o=0, loss_count_o=0, loss_sticky_o=0
- rst_o and ready_o are registered and decoded from the next state, so they change on the same edge as the state transition.
- Counter width is clog2(max(LOCK_FILTER, HOLD_CYCLES)) + 1 bits.
- States and transitions, evaluated each edge with reset low:
  - WAIT_LOCK: if lock_s=1, go to FILTER with cnt=0.
  - FILTER:
    - if lock_s=0, go to WAIT_LOCK (glitch rejected; not counted as a loss);
    - else if cnt==LOCK_FILTER-1, go to HOLD with cnt=0;
    - else cnt+1.
  - HOLD:
    - if lock_s=0, go to WAIT_LOCK (not counted);
    - else if cnt==HOLD_CYCLES-1, go to RUN;
    - else cnt+1.
  - RUN:
    - if lock_s=0, go to WAIT_LOCK, set loss_sticky_o=1, and increment loss_count_o, saturating at 2^LOSS_CNT_W-1.
- rst_o=1 in every state except RUN.
- Latency, lock-up: let edge 1 be the first rising edge sampling locked_i=1. With locked_i held high, rst_o falls (and ready_o rises) on edge LOCK_FILTER+HOLD_CYCLES+3. With defaults this is edge 1043.
- Latency, loss: let edge 1 be the first edge sampling locked_i=0 while in RUN. rst_o rises on edge 3. loss_count_o and loss_sticky_o update on that same edge.
- Any lock_s=0 during FILTER or HOLD restarts the full sequence, including the filter.
- clear_i:
  - clears loss_count_o and loss_sticky_o on the next edge;
  - does not affect the state or rst_o.
- clear_i in the same cycle as a RUN loss: the loss wins, giving loss_count_o=1 and loss_sticky_o=1.
- reset asserted mid-operation, including from RUN: next edge gives rst_o=1, ready_o=0, and all counters cleared. reset overrides clear_i and loss.
- Saturation: once loss_count_o is all-ones it holds until clear_i or reset.

Test Plan:
1. Lock-up. LOCK_FILTER=4, HOLD_CYCLES=8; reset, then locked_i=1 steady. Required: rst_o=1 through edge 14; rst_o=0 and ready_o=1 on edge 15 and after; loss_count_o=0.
2. Glitch rejection. Same params; locked_i pulses high for 3 edges then low. Then high for 2 edges during HOLD, following a full filter pass. Required: rst_o stays 1 throughout; loss_count_o=0; a fresh steady lock still needs the full 15 edges.
3. Loss in RUN. After RUN, drop locked_i. Required: rst_o=1 on the 3rd edge; loss_count_o=1; loss_sticky_o=1. Re-lock returns to RUN after 15 edges.
4. Saturation and clear. LOSS_CNT_W=2; 5 RUN losses. Required: loss_count_o=3. Then clear_i pulse gives count 0 and sticky 0 with rst_o unaffected. clear_i coincident with a loss gives count 1 and sticky 1.
5. Mid-operation reset. Assert reset for 1 cycle during HOLD, and again during RUN with loss_count_o=2. Required: next edge rst_o=1, ready_o=0, loss_count_o=0; the full 15-edge sequence is needed again.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Turns the asynchronous PLL lock flag into a filtered, stretched reset and ready
// flag for the local clock domain, and counts lock losses seen while running.
module pll_reset_sequencer #(
  parameter int LOCK_FILTER = 16,
  parameter int HOLD_CYCLES = 1024,
  parameter int LOSS_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  locked_i,
  input  logic                  clear_i,
  output logic                  rst_o,
  output logic                  ready_o,
  output logic [LOSS_CNT_W-1:0] loss_count_o,
  output logic                  loss_sticky_o
);

  localparam int MAX_CYC = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0]      FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0]      HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX    = '1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    sync1_q;
  logic                    sync2_q;
  logic                    rst_q;
  logic                    ready_q;
  logic [LOSS_CNT_W-1:0]   loss_cnt_q;
  logic                    sticky_q;

  logic                    lock_s;
  logic                    run_loss;

  assign lock_s   = sync2_q;
  assign run_loss = (state_q == RUN) && !lock_s;

  // Two-flop synchroniser; locked_i has no relation to clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= locked_i;
      sync2_q <= sync1_q;
    end
  end

  // Sequencer. rst_q/ready_q are decoded from the state being entered so they
  // move on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      rst_q   <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      rst_q   <= 1'b1;
      ready_q <= 1'b0;
      case (state_q)
        WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= FILTER;
            cnt_q   <= '0;
          end
        end
        FILTER: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == FILTER_LAST) begin
            state_q <= HOLD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_q <= RUN;
            cnt_q   <= '0;
            rst_q   <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else begin
            rst_q   <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= WAIT_LOCK;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // A loss in the same cycle as clear_i wins: the clear wipes history and this
  // loss becomes the first one recorded.
  always_ff @(posedge clk) begin
    if (reset) begin
      loss_cnt_q <= '0;
      sticky_q   <= 1'b0;
    end else if (run_loss) begin
      sticky_q <= 1'b1;
      if (clear_i) begin
        loss_cnt_q <= LOSS_CNT_W'(1);
      end else if (loss_cnt_q != LOSS_MAX) begin
        loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
      end
    end else if (clear_i) begin
      loss_cnt_q <= '0;
      sticky_q   <= 1'b0;
    end
  end

  assign rst_o         = rst_q;
  assign ready_o       = ready_q;
  assign loss_count_o  = loss_cnt_q;
  assign loss_sticky_o = sticky_q;

endmodule
